// File: rtl/tft_8080_bus_ctrl.sv
// 8080-style write-only TFT panel bus controller: word FIFO, write-strobe
// timing and a panel reset sequence.
module tft_8080_bus_ctrl #(
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned WR_LOW_CYC     = 2,
   parameter int unsigned WR_HIGH_CYC    = 2,
   parameter int unsigned RESET_LOW_CYC  = 500,
   parameter int unsigned RESET_WAIT_CYC = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_rs,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          panel_rst_req,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          tftRD,
   output logic                          tftWR,
   output logic                          tftRS,
   output logic                          tftRESET,
   output logic [DATA_W-1:0]             tftData
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned LW    = AW + 1;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned ENT_W = DATA_W + 1;

   localparam logic [CNT_W-1:0] RL_LOAD = CNT_W'(RESET_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] RW_LOAD = CNT_W'(RESET_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] WL_LOAD = CNT_W'(WR_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] WH_LOAD = CNT_W'(WR_HIGH_CYC - 1);

   localparam logic [2:0] ST_RST_LOW  = 3'd0;
   localparam logic [2:0] ST_RST_WAIT = 3'd1;
   localparam logic [2:0] ST_IDLE     = 3'd2;
   localparam logic [2:0] ST_SETUP    = 3'd3;
   localparam logic [2:0] ST_WR_LO    = 3'd4;
   localparam logic [2:0] ST_WR_HI    = 3'd5;

   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cnt_done;
   logic             pending;
   logic             pending_nxt;

   assign full     = (fifo_level == LW'(FIFO_DEPTH));
   assign empty    = (fifo_level == '0);
   assign in_ready = !rst && !full;
   assign push     = in_valid && in_ready;
   assign busy     = (state != ST_IDLE) || !empty;
   assign tftRD    = 1'b1;
   assign cnt_done = (cnt == '0);

   // FIFO storage; pushes are gated by the registered level so a full FIFO never accepts
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_rs, in_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: ;
         endcase
      end
   end

   // Sequencer: reset requests mid-word are deferred until the word's high phase ends
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      pop         = 1'b0;
      case (state)
         ST_RST_LOW: begin
            if (panel_rst_req) begin
               cnt_nxt = RL_LOAD;
            end else if (cnt_done) begin
               state_nxt = ST_RST_WAIT;
               cnt_nxt   = RW_LOAD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_RST_WAIT: begin
            if (panel_rst_req) begin
               state_nxt = ST_RST_LOW;
               cnt_nxt   = RL_LOAD;
            end else if (cnt_done) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_IDLE: begin
            if (panel_rst_req) begin
               state_nxt   = ST_RST_LOW;
               cnt_nxt     = RL_LOAD;
               pending_nxt = 1'b0;
            end else if (!empty) begin
               pop       = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (panel_rst_req) pending_nxt = 1'b1;
            state_nxt = ST_WR_LO;
            cnt_nxt   = WL_LOAD;
         end
         ST_WR_LO: begin
            if (panel_rst_req) pending_nxt = 1'b1;
            if (cnt_done) begin
               state_nxt = ST_WR_HI;
               cnt_nxt   = WH_LOAD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_WR_HI: begin
            if (panel_rst_req) pending_nxt = 1'b1;
            if (cnt_done) begin
               if (pending || panel_rst_req) begin
                  state_nxt   = ST_RST_LOW;
                  cnt_nxt     = RL_LOAD;
                  pending_nxt = 1'b0;
               end else if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = ST_SETUP;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt   = ST_RST_LOW;
            cnt_nxt     = RL_LOAD;
            pending_nxt = 1'b0;
         end
      endcase
   end

   // Panel pins are registered from the next state so they line up with the state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_RST_LOW;
         cnt      <= RL_LOAD;
         pending  <= 1'b0;
         tftWR    <= 1'b1;
         tftRESET <= 1'b0;
         tftRS    <= 1'b0;
         tftData  <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pending  <= pending_nxt;
         tftWR    <= (state_nxt != ST_WR_LO);
         tftRESET <= (state_nxt != ST_RST_LOW);
         if (pop) begin
            tftRS   <= mem[rd_ptr][DATA_W];
            tftData <= mem[rd_ptr][DATA_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_tft_8080_bus_ctrl.sv
// Directed self-checking bench for tft_8080_bus_ctrl (16-bit and 8-bit builds).
module tb_tft_8080_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_rs = 1'b0;
   logic [15:0] in_data = '0;
   logic        panel_rst_req = 1'b0;
   logic        busy;
   logic [4:0]  fifo_level;
   logic        tftRD, tftWR, tftRS, tftRESET;
   logic [15:0] tftData;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic        in_rs8 = 1'b0;
   logic [7:0]  in_data8 = '0;
   logic        busy8;
   logic [4:0]  fifo_level8;
   logic        tftRD8, tftWR8, tftRS8, tftRESET8;
   logic [7:0]  tftData8;

   always #5 clk = ~clk;

   tft_8080_bus_ctrl #(.DATA_W(16), .FIFO_DEPTH(16), .WR_LOW_CYC(2), .WR_HIGH_CYC(2),
                       .RESET_LOW_CYC(4), .RESET_WAIT_CYC(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
      .in_data(in_data), .panel_rst_req(panel_rst_req), .busy(busy), .fifo_level(fifo_level),
      .tftRD(tftRD), .tftWR(tftWR), .tftRS(tftRS), .tftRESET(tftRESET), .tftData(tftData));

   tft_8080_bus_ctrl #(.DATA_W(8), .FIFO_DEPTH(16), .WR_LOW_CYC(2), .WR_HIGH_CYC(2),
                       .RESET_LOW_CYC(4), .RESET_WAIT_CYC(6)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_rs(in_rs8),
      .in_data(in_data8), .panel_rst_req(1'b0), .busy(busy8), .fifo_level(fifo_level8),
      .tftRD(tftRD8), .tftWR(tftWR8), .tftRS(tftRS8), .tftRESET(tftRESET8), .tftData(tftData8));

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Strobe / reset-pulse monitor, sampled on the falling clock edge
   logic [16:0] stb_q[$];
   int          start_q[$];
   int          low_q[$];
   int          rl_q[$];
   int          cyc = 0;
   bit          prev_wr = 1'b1;
   int          low_cnt = 0;
   int          rl_cnt = 0;
   logic [16:0] cur_word = '0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_wr = 1'b1;
         low_cnt = 0;
         rl_cnt  = 0;
      end else begin
         if (!tftWR) begin
            if (prev_wr) begin
               cur_word = {tftRS, tftData};
               stb_q.push_back(cur_word);
               start_q.push_back(cyc);
            end else begin
               check("wr_lo_stable", 32'({tftRS, tftData}), 32'(cur_word));
            end
            low_cnt++;
         end else if (!prev_wr) begin
            low_q.push_back(low_cnt);
            low_cnt = 0;
         end
         prev_wr = tftWR;
         if (!tftRESET) rl_cnt++;
         else if (rl_cnt != 0) begin
            rl_q.push_back(rl_cnt);
            rl_cnt = 0;
         end
      end
   end

   function automatic logic [16:0] stb_at(input int i);
      return (i < stb_q.size()) ? stb_q[i] : 17'h1FFFF;
   endfunction

   function automatic int int_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clear_logs();
      stb_q.delete();
      start_q.delete();
      low_q.delete();
      rl_q.delete();
   endtask

   // Called on a falling edge; the word is pushed on the following rising edge
   task automatic push_word(input logic rs, input logic [15:0] data);
      in_valid = 1'b1;
      in_rs    = rs;
      in_data  = data;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_wr_low(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!tftWR) break;
         @(negedge clk);
      end
      check("wr_lo_seen", 32'(tftWR), 32'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_tftRESET", 32'(tftRESET), 32'(0));
      check("rst_tftWR", 32'(tftWR), 32'(1));
      check("rst_tftRD", 32'(tftRD), 32'(1));
      check("rst_tftRS", 32'(tftRS), 32'(0));
      check("rst_tftData", 32'(tftData), 32'(0));
      check("rst_busy", 32'(busy), 32'(1));
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_level", 32'(fifo_level), 32'(0));

      // Init sequence: 4 cycles low, 6 high, busy drops on cycle 10
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         #2;
         check($sformatf("init_tftRESET_c%0d", k), 32'(tftRESET), (k < 4) ? 32'(0) : 32'(1));
         if (k >= 9) check($sformatf("init_busy_c%0d", k), 32'(busy), (k < 10) ? 32'(1) : 32'(0));
         @(negedge clk);
      end
      check("init_in_ready", 32'(in_ready), 32'(1));

      // Two back-to-back words
      clear_logs();
      push_word(1'b0, 16'h002C);
      push_word(1'b1, 16'hF800);
      repeat (20) @(negedge clk);
      check("two_count", 32'(stb_q.size()), 32'(2));
      check("two_w0", 32'(stb_at(0)), 32'({1'b0, 16'h002C}));
      check("two_w1", 32'(stb_at(1)), 32'({1'b1, 16'hF800}));
      check("two_low0", 32'(int_at(low_q, 0)), 32'(2));
      check("two_low1", 32'(int_at(low_q, 1)), 32'(2));
      check("two_period", 32'(int_at(start_q, 1) - int_at(start_q, 0)), 32'(5));
      check("two_busy", 32'(busy), 32'(0));

      // Fill the FIFO while the panel is held in reset
      clear_logs();
      panel_rst_req = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1;
         in_rs    = 1'(i % 2);
         in_data  = (i == 16) ? 16'hDEAD : 16'(16'h1000 + i);
         if (i == 16) begin
            check("full_level", 32'(fifo_level), 32'(16));
            check("full_in_ready", 32'(in_ready), 32'(0));
            check("full_tftRESET", 32'(tftRESET), 32'(0));
         end
         @(negedge clk);
      end
      in_valid      = 1'b0;
      panel_rst_req = 1'b0;
      repeat (6) @(negedge clk);
      check("wait_tftRESET", 32'(tftRESET), 32'(1));
      check("wait_level", 32'(fifo_level), 32'(16));
      repeat (100) @(negedge clk);
      check("full_count", 32'(stb_q.size()), 32'(16));
      for (int i = 0; i < 16; i++)
         check($sformatf("full_w%0d", i), 32'(stb_at(i)), 32'({1'(i % 2), 16'(16'h1000 + i)}));
      check("full_drain_level", 32'(fifo_level), 32'(0));

      // Panel reset request during the first of three words
      clear_logs();
      push_word(1'b0, 16'h0011);
      push_word(1'b1, 16'h0022);
      push_word(1'b1, 16'h0033);
      wait_wr_low(20);
      panel_rst_req = 1'b1;
      @(negedge clk);
      panel_rst_req = 1'b0;
      repeat (40) @(negedge clk);
      check("prr_count", 32'(stb_q.size()), 32'(3));
      check("prr_w0", 32'(stb_at(0)), 32'({1'b0, 16'h0011}));
      check("prr_w1", 32'(stb_at(1)), 32'({1'b1, 16'h0022}));
      check("prr_w2", 32'(stb_at(2)), 32'({1'b1, 16'h0033}));
      check("prr_rst_runs", 32'(rl_q.size()), 32'(1));
      check("prr_rst_low", 32'(int_at(rl_q, 0)), 32'(4));
      check("prr_gap01", 32'(int_at(start_q, 1) - int_at(start_q, 0)), 32'(16));
      check("prr_gap12", 32'(int_at(start_q, 2) - int_at(start_q, 1)), 32'(5));

      // Hard reset in the middle of a strobe
      push_word(1'b0, 16'h0A0A);
      push_word(1'b1, 16'h0B0B);
      wait_wr_low(20);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_tftWR", 32'(tftWR), 32'(1));
      check("mid_rst_tftRESET", 32'(tftRESET), 32'(0));
      check("mid_rst_level", 32'(fifo_level), 32'(0));
      check("mid_rst_in_ready", 32'(in_ready), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
      repeat (30) @(negedge clk);
      check("mid_rst_no_strobe", 32'(stb_q.size()), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));

      // 8-bit build
      in_valid8 = 1'b1;
      in_rs8    = 1'b1;
      in_data8  = 8'hA5;
      @(negedge clk);
      in_valid8 = 1'b0;
      check("b8_level", 32'(fifo_level8), 32'(1));
      for (int i = 0; i < 10; i++) begin
         if (!tftWR8) break;
         @(negedge clk);
      end
      check("b8_wr_lo", 32'(tftWR8), 32'(0));
      check("b8_data", 32'(tftData8), 32'(8'hA5));
      check("b8_rs", 32'(tftRS8), 32'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
